// File: rtl/iter_shifter_pkg.sv
// Shared shift-path definitions: op encodings and FSM state encodings.
// Also imported by the ALU decoder so both agree on the op numbering.
package iter_shifter_pkg;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_SLL = 3'd1,
    OP_ROR = 3'd2,
    OP_ASR = 3'd3,
    OP_SRL = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] OP_LAST = 3'd4;

  // Encodings 5..7 are reserved and pass the operand through unchanged.
  function automatic logic op_reserved(input logic [2:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single combinational shift stage: applies 0..STEP positions of one op.
// Built as STEP chained one-position shifts so every op shares one structure.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2,
  parameter int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    amt,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(amt)) begin
        case (op)
          OP_ROL:  result = {result[WIDTH-2:0], result[WIDTH-1]};
          OP_SLL:  result = {result[WIDTH-2:0], 1'b0};
          OP_ROR:  result = {result[0], result[WIDTH-1:1]};
          OP_ASR:  result = {result[WIDTH-1], result[WIDTH-1:1]};
          OP_SRL:  result = {1'b0, result[WIDTH-1:1]};
          default: result = result;
        endcase
      end
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle iterative shifter: consumes up to STEP positions per cycle,
// with valid/ready on both sides and back-to-back accept from DONE.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int SW = $clog2(STEP + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high in IDLE, and in DONE it follows out_ready so a new
  // request can enter on the same edge the previous result leaves.
  state_e           state;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] remaining;
  logic [SW-1:0]    step_amt;
  logic [WIDTH-1:0] step_data;
  logic [AMT_W-1:0] remaining_next;
  logic             accept;
  logic             bypass;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign bypass   = (in_amt == '0) || op_reserved(in_op);
  assign out_data = data_q;

  // A remaining count below STEP always fits SW bits, so the narrowing is safe.
  always_comb begin
    if (int'(remaining) < STEP) step_amt = SW'(remaining);
    else                        step_amt = SW'(STEP);
  end

  assign remaining_next = remaining - AMT_W'(step_amt);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .SW    (SW)
  ) u_step (
    .data   (data_q),
    .op     (op_q),
    .amt    (step_amt),
    .result (step_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      op_q      <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          data_q    <= step_data;
          remaining <= remaining_next;
          if (remaining_next == '0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            data_q <= in_data;
            op_q   <= in_op;
            busy   <= 1'b1;
            if (bypass) begin
              state     <= ST_DONE;
              remaining <= '0;
              out_valid <= 1'b1;
            end else begin
              state     <= ST_SHIFT;
              remaining <= in_amt;
              out_valid <= 1'b0;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: transaction-level reference model with a
// per-cycle compare process, directed corner cases and random traffic.
module tb_iter_shifter;
  localparam int WIDTH = 16;
  localparam int STEP  = 2;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int cnt       = 0;
  bit mv        = 0;
  bit inflight  = 0;
  bit acc_flag  = 0;
  bit rst_seen  = 0;
  bit rand_ready = 0;

  iter_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference: a single shift by amt, straight from the op definitions.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [2:0] op, input int amt);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = (d << amt) | (d >> (WIDTH - amt));
      3'd1:    r = d << amt;
      3'd2:    r = (d >> amt) | (d << (WIDTH - amt));
      3'd3:    r = WIDTH'($signed(d) >>> amt);
      3'd4:    r = d >> amt;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input int amt);
    if (op > 3'd4 || amt == 0) return 0;
    return (amt + STEP - 1) / STEP;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process / scoreboard: inputs are stable 2 time units after negedge
  always begin
    bit exp_ir, out_hs, in_hs;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp_q.delete();
      cnt = 0; mv = 0; inflight = 0; acc_flag = 0; rst_seen = 1;
    end else begin
      exp_ir = !inflight || (mv && out_ready);
      if (rst_seen) check("reset_out_data", 32'(out_data), 32'h0);
      rst_seen = 0;
      check("out_valid", 32'(out_valid), 32'(mv));
      check("busy", 32'(busy), 32'(inflight));
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      if (mv && exp_q.size() > 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
      out_hs = mv && out_ready;
      in_hs  = in_valid && exp_ir;
      if (out_hs) begin
        void'(exp_q.pop_front());
        mv = 0; inflight = 0;
      end else if (inflight && !mv) begin
        cnt--;
        if (cnt == 0) mv = 1;
      end
      if (in_hs) begin
        exp_q.push_back(ref_shift(in_data, in_op, int'(in_amt)));
        inflight = 1;
        cnt = ref_lat(in_op, int'(in_amt));
        mv = (cnt == 0);
      end
      acc_flag = in_hs;
    end
  end

  always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);

  // driver tasks: called at a negedge, return at the negedge after acceptance
  task automatic send(input logic [WIDTH-1:0] d, input logic [2:0] op,
                      input logic [AMT_W-1:0] amt);
    int guard;
    in_valid = 1'b1; in_data = d; in_op = op; in_amt = amt;
    guard = 0;
    #3;
    while (!acc_flag && guard < 200) begin
      @(negedge clk); #3; guard++;
    end
    if (!acc_flag) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: request not accepted within %0d cycles", guard);
    end
    @(negedge clk);
  endtask

  task automatic wait_result(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(negedge clk); edges++;
    end
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] d, input logic [2:0] op,
                          input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] lit,
                          input int lit_lat);
    int e;
    check({"model_", name}, 32'(ref_shift(d, op, int'(amt))), 32'(lit));
    out_ready = 1'b1;
    send(d, op, amt);
    in_valid = 1'b0;
    wait_result(e);
    check({name, "_latency"}, 32'(e), 32'(lit_lat));
    check({name, "_data"}, 32'(out_data), 32'(lit));
    @(negedge clk);
  endtask

  initial begin
    int e;
    logic [2:0] rop;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    directed("rol3",   16'h8001, 3'd0, 4'd3,  16'h000C, 2);
    directed("asr15",  16'h8000, 3'd3, 4'd15, 16'hFFFF, 8);
    directed("srl15",  16'h8000, 3'd4, 4'd15, 16'h0001, 8);
    directed("ror1",   16'h0001, 3'd2, 4'd1,  16'h8000, 1);
    directed("sll0",   16'h1234, 3'd1, 4'd0,  16'h1234, 0);
    directed("resv6",  16'hABCD, 3'd6, 4'd5,  16'hABCD, 0);

    // backpressure then back-to-back accept
    out_ready = 1'b0;
    send(16'h0F00, 3'd0, 4'd4);
    in_valid = 1'b0;
    wait_result(e);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(out_data), 32'hF000);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(16'h0001, 3'd1, 4'd2);
    in_valid = 1'b0;
    wait_result(e);
    check("b2b_latency", 32'(e), 32'h1);
    check("b2b_data", 32'(out_data), 32'h0004);
    @(negedge clk);

    // reset during SHIFT discards the operation
    send(16'h8000, 3'd3, 4'd14);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    repeat (10) @(negedge clk);

    // random traffic with output stalls
    rand_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      rop = 3'($urandom_range(0, 7));
      send(WIDTH'($urandom), rop, AMT_W'($urandom_range(0, WIDTH - 1)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    rand_ready = 0;
    out_ready = 1'b1;
    e = 0;
    while ((exp_q.size() != 0 || busy) && e < 500) begin
      @(negedge clk); e++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
